// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_ir,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_imm,
    output logic [2:0]          out_fmt,
    output logic                out_illegal,
    output logic [31:0]         out_ir,
    output logic [PC_WIDTH-1:0] out_pc
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam int EW = WIDTH + 3 + 1 + 32 + PC_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   head_q, head_d;
    logic [EW-1:0]   tail_q, tail_d;

    logic [2:0]       dec_fmt;
    logic             dec_illegal;
    logic [31:0]      imm32;
    logic [WIDTH-1:0] imm_ext;
    logic [EW-1:0]    in_entry;
    logic             push;
    logic             pop;

    always_comb begin
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        unique case (in_ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FMT_I;
            7'b0100011:                         dec_fmt = FMT_S;
            7'b1100011:                         dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:             dec_fmt = FMT_U;
            7'b1101111:                         dec_fmt = FMT_J;
            7'b1110011:                         dec_fmt = in_ir[14] ? FMT_Z : FMT_I;
            default:                            dec_illegal = 1'b1;
        endcase
    end

    // Z leaves bit 31 clear, so one sign-extension of imm32 covers every format.
    always_comb begin
        imm32 = 32'd0;
        case (dec_fmt)
            FMT_I:   imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
            FMT_S:   imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
            FMT_B:   imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25],
                              in_ir[11:8], 1'b0};
            FMT_U:   imm32 = {in_ir[31:12], 12'd0};
            FMT_J:   imm32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20],
                              in_ir[30:21], 1'b0};
            FMT_Z:   imm32 = {27'd0, in_ir[19:15]};
            default: imm32 = 32'd0;
        endcase
        imm_ext        = {WIDTH{imm32[31]}};
        imm_ext[31:0]  = imm32;
    end

    assign in_entry = {imm_ext, dec_fmt, dec_illegal, in_ir, in_pc};

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign {out_imm, out_fmt, out_illegal, out_ir, out_pc} = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        tail_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed vector bench for imm_gen_pipe (32 and 64 bit)
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_ir32, out_pc32;
    logic [2:0]  out_fmt32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_ir64, out_pc64;
    logic [2:0]  out_fmt64;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.WIDTH(32), .PC_WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_ir(out_ir32),
        .out_pc(out_pc32)
    );

    imm_gen_pipe #(.WIDTH(64), .PC_WIDTH(32)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_ir(out_ir64),
        .out_pc(out_pc64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vec[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [31:0] pc);
        in_valid = 1'b1;
        in_ir    = vec[k].ir;
        in_pc    = pc;
    endtask

    task automatic chk_head(input string tag, input int k, input logic [31:0] pc);
        chk({tag, " valid32"}, {63'd0, out_valid32}, 64'd1);
        chk({tag, " valid64"}, {63'd0, out_valid64}, 64'd1);
        chk({tag, " imm32"},   {32'd0, out_imm32}, {32'd0, vec[k].imm[31:0]});
        chk({tag, " imm64"},   out_imm64, vec[k].imm);
        chk({tag, " fmt"},     {61'd0, out_fmt32}, {61'd0, vec[k].fmt});
        chk({tag, " fmt64"},   {61'd0, out_fmt64}, {61'd0, vec[k].fmt});
        chk({tag, " illegal"}, {63'd0, out_illegal32}, {63'd0, vec[k].ill});
        chk({tag, " ir"},      {32'd0, out_ir32}, {32'd0, vec[k].ir});
        chk({tag, " pc"},      {32'd0, out_pc32}, {32'd0, pc});
    endtask

    task automatic chk_flags(input string tag, input logic valid, input logic ready);
        chk({tag, " out_valid32"}, {63'd0, out_valid32}, {63'd0, valid});
        chk({tag, " out_valid64"}, {63'd0, out_valid64}, {63'd0, valid});
        chk({tag, " in_ready32"},  {63'd0, in_ready32},  {63'd0, ready});
        chk({tag, " in_ready64"},  {63'd0, in_ready64},  {63'd0, ready});
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ir     = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;

        vec[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vec[1]  = '{32'h0040006F, 64'h0000000000000004, 3'd5, 1'b0};
        vec[2]  = '{32'hFE000FE3, 64'hFFFFFFFFFFFFFFFE, 3'd3, 1'b0};
        vec[3]  = '{32'h12345037, 64'h0000000012345000, 3'd4, 1'b0};
        vec[4]  = '{32'h000FD073, 64'h000000000000001F, 3'd6, 1'b0};
        vec[5]  = '{32'h0000007F, 64'h0000000000000000, 3'd0, 1'b1};
        vec[6]  = '{32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vec[7]  = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
        vec[8]  = '{32'h00812083, 64'h0000000000000008, 3'd1, 1'b0};
        vec[9]  = '{32'h30029073, 64'h0000000000000300, 3'd1, 1'b0};
        vec[10] = '{32'hFFC08067, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
        vec[11] = '{32'hFFFFF017, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0};
        vec[12] = '{32'h00208033, 64'h0000000000000000, 3'd0, 1'b1};
        vec[13] = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};

        // Reset state, sampled while rst_n is still low.
        #12;
        chk_flags("reset", 1'b0, 1'b1);
        chk("reset imm64", out_imm64, 64'd0);
        chk("reset imm32", {32'd0, out_imm32}, 64'd0);
        chk("reset fmt", {61'd0, out_fmt32}, 64'd0);
        chk("reset illegal", {63'd0, out_illegal32}, 64'd0);
        chk("reset ir", {32'd0, out_ir32}, 64'd0);
        chk("reset pc", {32'd0, out_pc32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream with the consumer always ready: one result per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(i, 32'h1000 + 32'(4 * i));
            tick();
            chk_head($sformatf("vec%0d", i), i, 32'h1000 + 32'(4 * i));
        end
        in_valid = 1'b0;
        tick();
        chk_flags("drain", 1'b0, 1'b1);

        // Backpressure: two accepted, third held by the source until space frees.
        out_ready = 1'b0;
        drive(0, 32'h2000);
        tick();
        chk_flags("bp one", 1'b1, 1'b1);
        drive(1, 32'h2004);
        tick();
        chk_flags("bp full", 1'b1, 1'b0);
        chk_head("bp head A", 0, 32'h2000);
        drive(2, 32'h2008);
        tick();
        tick();
        chk_flags("bp hold", 1'b1, 1'b0);
        chk_head("bp stable A", 0, 32'h2000);
        out_ready = 1'b1;
        tick();
        chk_head("bp head B", 1, 32'h2004);
        chk_flags("bp after pop", 1'b1, 1'b1);
        tick();
        chk_head("bp head C", 2, 32'h2008);
        in_valid = 1'b0;
        tick();
        chk_flags("bp empty", 1'b0, 1'b1);

        // Flush while FULL with the source still presenting a word.
        out_ready = 1'b0;
        drive(3, 32'h3000);
        tick();
        drive(4, 32'h3004);
        tick();
        chk_flags("fl full", 1'b1, 1'b0);
        flush = 1'b1;
        drive(5, 32'h3008);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_flags("fl full after", 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        tick();
        chk_flags("fl full quiet", 1'b0, 1'b1);

        // Flush in ONE against a push that would otherwise be accepted.
        out_ready = 1'b0;
        drive(6, 32'h3100);
        tick();
        flush = 1'b1;
        drive(7, 32'h3104);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_flags("fl one after", 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        chk_flags("fl one quiet", 1'b0, 1'b1);

        // 64-bit U sign extension, then asynchronous reset mid-cycle.
        out_ready = 1'b0;
        drive(6, 32'h4000);
        tick();
        in_valid = 1'b0;
        chk_head("rst pre", 6, 32'h4000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_flags("async rst", 1'b0, 1'b1);
        chk("async rst imm64", out_imm64, 64'd0);
        chk("async rst ir", {32'd0, out_ir32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_flags("post rst", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
